// File: rtl/matrix_slot_writer_if.sv
// Result-write bundle between the compute subsystem and the matrix slot
// writer, including the writer's BRAM write port.
interface matrix_slot_writer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14
);
  logic                  write_request;
  logic                  write_ready;
  logic [2:0]            write_matrix_id;
  logic [7:0]            write_rows;
  logic [7:0]            write_cols;
  logic [0:7][7:0]       write_name;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  write_data_valid;
  logic                  writer_ready;
  logic                  write_done;
  logic                  write_error;
  logic                  busy;
  logic                  bram_we;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [DATA_WIDTH-1:0] bram_din;

  // Producer side: issues requests and payload, observes status and BRAM port.
  modport master (
    output write_request, write_matrix_id, write_rows, write_cols, write_name,
           write_data, write_data_valid,
    input  write_ready, writer_ready, write_done, write_error, busy,
           bram_we, bram_addr, bram_din
  );

  // Writer side.
  modport slave (
    input  write_request, write_matrix_id, write_rows, write_cols, write_name,
           write_data, write_data_valid,
    output write_ready, writer_ready, write_done, write_error, busy,
           bram_we, bram_addr, bram_din
  );
endinterface

// File: rtl/matrix_slot_writer.sv
// Commits one matrix per transaction into its BRAM slot at id*BLOCK_SIZE.
// Payload goes first, the 3-word header last (base+2, base+1, base+0), so an
// interrupted transfer never leaves a header that looks valid.
//
// state | meaning
// IDLE  | waiting for write_request, write_ready=1
// CHECK | validate latched dimensions
// DATA  | accept payload words, one BRAM write per transfer
// HDR2  | write name bytes 4..7 to base+2
// HDR1  | write name bytes 0..3 to base+1
// HDR0  | write {rows,cols} to base+0
// DONE  | write_done pulse
// ERR   | write_error pulse, nothing was written
module matrix_slot_writer #(
  parameter int BLOCK_SIZE = 1152,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14
) (
  input logic                 clk,
  input logic                 rst,
  matrix_slot_writer_if.slave wif
);

  typedef enum logic [2:0] {
    IDLE, CHECK, DATA, HDR2, HDR1, HDR0, DONE, ERR
  } state_t;

  localparam logic [15:0] MAX_PAYLOAD = 16'(BLOCK_SIZE - 3);

  state_t                state;
  logic [2:0]            id_q;
  logic [7:0]            rows_q;
  logic [7:0]            cols_q;
  logic [0:7][7:0]       name_q;
  logic [15:0]           count;
  logic                  write_ready_q;
  logic                  writer_ready_q;
  logic                  write_done_q;
  logic                  write_error_q;
  logic                  busy_q;
  logic                  bram_we_q;
  logic [ADDR_WIDTH-1:0] bram_addr_q;
  logic [DATA_WIDTH-1:0] bram_din_q;

  logic [15:0]           total;
  logic [ADDR_WIDTH-1:0] base;

  assign total = 16'(rows_q) * 16'(cols_q);
  assign base  = ADDR_WIDTH'(id_q) * ADDR_WIDTH'(BLOCK_SIZE);

  assign wif.write_ready  = write_ready_q;
  assign wif.writer_ready = writer_ready_q;
  assign wif.write_done   = write_done_q;
  assign wif.write_error  = write_error_q;
  assign wif.busy         = busy_q;
  assign wif.bram_we      = bram_we_q;
  assign wif.bram_addr    = bram_addr_q;
  assign wif.bram_din     = bram_din_q;

  // Sequencer: all outputs registered; pulses default low every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      id_q           <= '0;
      rows_q         <= '0;
      cols_q         <= '0;
      name_q         <= '0;
      count          <= '0;
      write_ready_q  <= 1'b1;
      writer_ready_q <= 1'b0;
      write_done_q   <= 1'b0;
      write_error_q  <= 1'b0;
      busy_q         <= 1'b0;
      bram_we_q      <= 1'b0;
      bram_addr_q    <= '0;
      bram_din_q     <= '0;
    end else begin
      bram_we_q     <= 1'b0;
      write_done_q  <= 1'b0;
      write_error_q <= 1'b0;
      case (state)
        IDLE: begin
          if (wif.write_request) begin
            id_q          <= wif.write_matrix_id;
            rows_q        <= wif.write_rows;
            cols_q        <= wif.write_cols;
            name_q        <= wif.write_name;
            write_ready_q <= 1'b0;
            busy_q        <= 1'b1;
            state         <= CHECK;
          end
        end
        CHECK: begin
          if (rows_q == 8'd0 || cols_q == 8'd0 || total > MAX_PAYLOAD) begin
            write_error_q <= 1'b1;
            state         <= ERR;
          end else begin
            count          <= '0;
            writer_ready_q <= 1'b1;
            state          <= DATA;
          end
        end
        DATA: begin
          if (wif.write_data_valid && writer_ready_q) begin
            bram_we_q   <= 1'b1;
            bram_addr_q <= base + ADDR_WIDTH'(3) + ADDR_WIDTH'(count);
            bram_din_q  <= wif.write_data;
            count       <= count + 16'd1;
            if (count == total - 16'd1) begin
              writer_ready_q <= 1'b0;
              state          <= HDR2;
            end
          end
        end
        HDR2: begin
          bram_we_q   <= 1'b1;
          bram_addr_q <= base + ADDR_WIDTH'(2);
          bram_din_q  <= DATA_WIDTH'({name_q[4], name_q[5], name_q[6], name_q[7]});
          state       <= HDR1;
        end
        HDR1: begin
          bram_we_q   <= 1'b1;
          bram_addr_q <= base + ADDR_WIDTH'(1);
          bram_din_q  <= DATA_WIDTH'({name_q[0], name_q[1], name_q[2], name_q[3]});
          state       <= HDR0;
        end
        HDR0: begin
          bram_we_q    <= 1'b1;
          bram_addr_q  <= base;
          bram_din_q   <= DATA_WIDTH'({16'h0, rows_q, cols_q});
          write_done_q <= 1'b1;
          state        <= DONE;
        end
        DONE, ERR: begin
          write_ready_q <= 1'b1;
          busy_q        <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_slot_writer.sv
// Randomized scoreboard bench for matrix_slot_writer. The driver predicts every
// BRAM write and done/error pulse from the slot layout rules; a monitor pops
// and compares whenever the DUT presents a write or a pulse.
module tb_matrix_slot_writer;

  localparam int BS = 1152;

  typedef struct {
    int unsigned addr;
    int unsigned data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matrix_slot_writer_if wif ();
  matrix_slot_writer dut (.clk(clk), .rst(rst), .wif(wif.slave));

  int n_checks = 0;
  int n_fail   = 0;

  wr_t         exp_wr[$];
  int          exp_ev[$];   // 0 = done, 1 = error
  int unsigned words[$];
  bit          vpat[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: compare outputs against predictions on the falling edge.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (wif.bram_we === 1'b1) begin
        if (exp_wr.size() == 0) chk("unexpected_bram_we", 1, 0);
        else begin
          e = exp_wr.pop_front();
          chk("bram_addr", 64'(wif.bram_addr), 64'(e.addr));
          chk("bram_din", 64'(wif.bram_din), 64'(e.data));
        end
      end
      if (wif.write_done === 1'b1) begin
        if (exp_ev.size() == 0) chk("unexpected_done", 1, 0);
        else chk("done_event", 0, 64'(exp_ev.pop_front()));
      end
      if (wif.write_error === 1'b1) begin
        if (exp_ev.size() == 0) chk("unexpected_error", 1, 0);
        else chk("error_event", 1, 64'(exp_ev.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic scramble_meta();
    wif.write_matrix_id = 3'($urandom);
    wif.write_rows      = 8'($urandom);
    wif.write_cols      = 8'($urandom);
    for (int i = 0; i < 8; i++) wif.write_name[i] = 8'($urandom);
  endtask

  task automatic fill_words(input int n, input bit seq);
    words.delete();
    for (int k = 0; k < n; k++) words.push_back(seq ? k + 1 : $urandom);
  endtask

  // One transaction. abort_at > 0 resets the DUT after that many transfers.
  task automatic do_txn(input logic [2:0] id, input logic [7:0] r, input logic [7:0] c,
                        input logic [63:0] nm, input bit gaps, input int abort_at);
    int total, base, sent, cyc, nwr;
    bit bad, v;
    total = int'(r) * int'(c);
    base  = int'(id) * BS;
    bad   = (r == 0) || (c == 0) || (total > BS - 3);
    cyc = 0;
    while (wif.write_ready !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
    chk("ready_before_request", 64'(wif.write_ready), 1);

    wif.write_request   = 1'b1;
    wif.write_matrix_id = id;
    wif.write_rows      = r;
    wif.write_cols      = c;
    for (int i = 0; i < 8; i++) wif.write_name[i] = nm[63-8*i -: 8];
    if (bad) exp_ev.push_back(1);
    else begin
      nwr = (abort_at > 0) ? abort_at : total;
      for (int k = 0; k < nwr; k++) exp_wr.push_back('{base + 3 + k, words[k]});
      if (abort_at == 0) begin
        exp_wr.push_back('{base + 2, nm[31:0]});
        exp_wr.push_back('{base + 1, nm[63:32]});
        exp_wr.push_back('{base, {16'h0, r, c}});
        exp_ev.push_back(0);
      end
    end
    @(negedge clk);
    wif.write_request = 1'b0;
    scramble_meta();

    if (bad) begin
      chk("error_not_early", 64'(wif.write_error), 0);
      @(negedge clk);
      chk("error_pulse_at_2", 64'(wif.write_error), 1);
      @(negedge clk);
      chk("ready_after_error", 64'(wif.write_ready), 1);
      chk("error_one_cycle", 64'(wif.write_error), 0);
      return;
    end

    nwr = (abort_at > 0) ? abort_at : total;
    sent = 0;
    cyc = 0;
    while (sent < nwr && cyc < 5000) begin
      if (vpat.size() > 0) v = vpat.pop_front();
      else v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      wif.write_data_valid = v;
      wif.write_data       = v ? words[sent] : $urandom;
      wif.write_request    = ($urandom_range(0, 2) == 0);
      scramble_meta();
      if (v && wif.writer_ready === 1'b1) sent++;
      if (sent < nwr) @(negedge clk);
      cyc++;
    end
    chk("stream_complete", 64'(sent), 64'(nwr));

    @(negedge clk);  // N+1
    wif.write_request    = 1'b0;
    wif.write_data_valid = 1'b0;
    if (abort_at > 0) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_ready", 64'(wif.write_ready), 1);
      chk("abort_busy", 64'(wif.busy), 0);
      chk("abort_no_we", 64'(wif.bram_we), 0);
      chk("abort_writer_ready", 64'(wif.writer_ready), 0);
      return;
    end
    wif.write_data_valid = 1'($urandom);   // junk valid outside DATA
    @(negedge clk);  // N+2
    @(negedge clk);  // N+3
    chk("done_not_early", 64'(wif.write_done), 0);
    @(negedge clk);  // N+4
    chk("done_at_n4", 64'(wif.write_done), 1);
    chk("not_ready_at_n4", 64'(wif.write_ready), 0);
    @(negedge clk);  // N+5
    wif.write_data_valid = 1'b0;
    chk("ready_at_n5", 64'(wif.write_ready), 1);
    chk("done_one_cycle", 64'(wif.write_done), 0);
  endtask

  initial begin
    logic [2:0]  id;
    logic [7:0]  r, c;
    logic [63:0] nm;
    wif.write_request    = 1'b0;
    wif.write_data_valid = 1'b0;
    wif.write_data       = '0;
    scramble_meta();
    repeat (3) @(negedge clk);
    chk("rst_write_ready", 64'(wif.write_ready), 1);
    chk("rst_writer_ready", 64'(wif.writer_ready), 0);
    chk("rst_done", 64'(wif.write_done), 0);
    chk("rst_error", 64'(wif.write_error), 0);
    chk("rst_busy", 64'(wif.busy), 0);
    chk("rst_we", 64'(wif.bram_we), 0);
    chk("rst_addr", 64'(wif.bram_addr), 0);
    chk("rst_din", 64'(wif.bram_din), 0);
    rst = 1'b0;
    // valid while idle must not write
    wif.write_data_valid = 1'b1;
    repeat (3) @(negedge clk);
    wif.write_data_valid = 1'b0;

    fill_words(6, 1);
    do_txn(3'd1, 8'd2, 8'd3, "MATRIXAB", 0, 0);
    do_txn(3'd2, 8'd0, 8'd5, "ZEROROWS", 0, 0);
    do_txn(3'd3, 8'd40, 8'd40, "TOOLARGE", 0, 0);
    fill_words(4, 0);
    vpat = '{1, 0, 0, 1, 0, 1, 1};
    do_txn(3'd0, 8'd1, 8'd4, "GAPPYVAL", 0, 0);
    fill_words(6, 0);
    do_txn(3'd4, 8'd2, 8'd3, "ABORTED!", 0, 2);
    fill_words(1, 0);
    do_txn(3'd7, 8'd1, 8'd1, "LASTSLOT", 0, 0);
    do_txn(3'd5, 8'd5, 8'd230, "EDGE1150", 0, 0);
    fill_words(1145, 0);
    do_txn(3'd6, 8'd5, 8'd229, "EDGE1145", 1, 0);

    for (int i = 0; i < 10; i++) begin
      id = 3'($urandom);
      r  = 8'($urandom_range(0, 9));
      c  = 8'($urandom_range(1, 9));
      if (i % 5 == 4) begin
        r = 8'($urandom_range(34, 255));
        c = 8'($urandom_range(34, 255));
      end
      nm = {$urandom, $urandom};
      fill_words(int'(r) * int'(c), 0);
      do_txn(id, r, c, nm, 1, 0);
    end

    repeat (5) @(negedge clk);
    chk("no_pending_writes", 64'(exp_wr.size()), 0);
    chk("no_pending_events", 64'(exp_ev.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
